// File: rtl/simt_scheduler_pkg.sv
// core_pkg: shared core, fetcher and LSU state encodings for the compute core.
package core_pkg;
    localparam int PC_BITS_DEFAULT = 8;
    localparam logic [2:0] CORE_IDLE    = 3'b000;
    localparam logic [2:0] CORE_FETCH   = 3'b001;
    localparam logic [2:0] CORE_DECODE  = 3'b010;
    localparam logic [2:0] CORE_REQUEST = 3'b011;
    localparam logic [2:0] CORE_WAIT    = 3'b100;
    localparam logic [2:0] CORE_EXECUTE = 3'b101;
    localparam logic [2:0] CORE_UPDATE  = 3'b110;
    localparam logic [2:0] CORE_DONE    = 3'b111;
    localparam logic [2:0] FETCHER_DONE = 3'b010;
    typedef enum logic [1:0] {
        LSU_IDLE       = 2'b00,
        LSU_REQUESTING = 2'b01,
        LSU_WAITING    = 2'b10,
        LSU_DONE       = 2'b11
    } lsu_state_e;
endpackage

// File: rtl/simt_scheduler_min_pc_select.sv
// min_pc_select: finds the lowest PC among live threads and which live threads sit on it.
module min_pc_select
    import core_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int PC_BITS = PC_BITS_DEFAULT
) (
    input  logic [THREADS-1:0] live,
    input  logic [PC_BITS-1:0] pc [THREADS],
    output logic [PC_BITS-1:0] min_pc,
    output logic [THREADS-1:0] match_mask,
    output logic               any_live
);
    always_comb begin
        min_pc = '1;
        match_mask = '0;
        for (int i = 0; i < THREADS; i++)
            if (live[i] && pc[i] < min_pc) min_pc = pc[i];
        for (int i = 0; i < THREADS; i++)
            match_mask[i] = live[i] && pc[i] == min_pc;
    end
    assign any_live = |live;
endmodule

// File: rtl/simt_scheduler.sv
// simt_scheduler: per-thread-PC core scheduler; runs the threads at the minimum PC so
// diverged threads reconverge when their PCs meet.
module simt_scheduler
    import core_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS = PC_BITS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [$clog2(THREADS_PER_BLOCK):0] thread_count,
    input  logic [2:0]                     fetcher_state,
    input  logic                           decoded_mem_read_enable,
    input  logic                           decoded_mem_write_enable,
    input  logic                           decoded_ret,
    input  logic [1:0]                     lsu_state [THREADS_PER_BLOCK],
    input  logic [PC_BITS-1:0]             next_pc [THREADS_PER_BLOCK],
    output logic [2:0]                     core_state,
    output logic [PC_BITS-1:0]             current_pc,
    output logic [THREADS_PER_BLOCK-1:0]   active_mask,
    output logic                           diverged,
    output logic                           done
);
    localparam int T = THREADS_PER_BLOCK;
    localparam int TCW = $clog2(T) + 1;
    logic [2:0] state_q, state_d;
    logic [PC_BITS-1:0] pc_q, pc_d, min_pc;
    logic [T-1:0] mask_q, mask_d, retired_q, retired_d, enabled_q, enabled_d;
    logic [T-1:0] live, match_mask, lsu_busy;
    logic div_q, div_d, done_q, done_d, any_live;
    logic [PC_BITS-1:0] thread_pc_q [T];
    logic [PC_BITS-1:0] thread_pc_d [T];

    min_pc_select #(.THREADS(T), .PC_BITS(PC_BITS)) u_min (
        .live(live),
        .pc(thread_pc_d),
        .min_pc(min_pc),
        .match_mask(match_mask),
        .any_live(any_live)
    );

    always_comb begin
        for (int i = 0; i < T; i++) begin
            lsu_busy[i] = mask_q[i] && (lsu_state[i] == LSU_REQUESTING || lsu_state[i] == LSU_WAITING);
            thread_pc_d[i] = (state_q == CORE_UPDATE && !decoded_ret && mask_q[i]) ? next_pc[i] : thread_pc_q[i];
            enabled_d[i] = (state_q == CORE_IDLE && start) ? TCW'(i) < thread_count : enabled_q[i];
        end
        retired_d = (state_q == CORE_UPDATE && decoded_ret) ? retired_q | mask_q : retired_q;
        live = enabled_q & ~retired_d;
        state_d = state_q;
        pc_d = pc_q;
        mask_d = mask_q;
        div_d = div_q;
        done_d = done_q;
        case (state_q)
            CORE_IDLE: if (start) begin
                state_d = (thread_count == '0) ? CORE_DONE : CORE_FETCH;
                done_d = thread_count == '0;
                pc_d = '0;
                mask_d = enabled_d;
            end
            CORE_FETCH:   if (fetcher_state == FETCHER_DONE) state_d = CORE_DECODE;
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            // Only threads executing this instruction can stall the memory wait.
            CORE_WAIT: if (!((decoded_mem_read_enable || decoded_mem_write_enable) && |lsu_busy))
                state_d = CORE_EXECUTE;
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                state_d = any_live ? CORE_FETCH : CORE_DONE;
                done_d = !any_live;
                pc_d = any_live ? min_pc : pc_q;
                mask_d = any_live ? match_mask : '0;
                div_d = any_live && match_mask != live;
            end
            default: state_d = CORE_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CORE_IDLE;
            pc_q <= '0;
            mask_q <= '0;
            div_q <= 1'b0;
            done_q <= 1'b0;
            retired_q <= '0;
            enabled_q <= '0;
            thread_pc_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            mask_q <= mask_d;
            div_q <= div_d;
            done_q <= done_d;
            retired_q <= retired_d;
            enabled_q <= enabled_d;
            thread_pc_q <= thread_pc_d;
        end
    end

    assign core_state = state_q;
    assign current_pc = pc_q;
    assign active_mask = mask_q;
    assign diverged = div_q;
    assign done = done_q;
endmodule

// File: tb/tb_simt_scheduler.sv
// tb_simt_scheduler: scoreboard bench; each instruction queues its expected post-UPDATE outputs.
module tb_simt_scheduler;
    import core_pkg::*;
    localparam int T = 4;
    localparam int PB = 8;
    typedef struct packed {
        logic [2:0] st;
        logic [7:0] pc;
        logic [3:0] mask;
        logic       dv;
        logic       dn;
    } exp_t;
    logic clk = 1'b0;
    logic reset, start, rd, wr, ret, diverged, done;
    logic [2:0] thread_count, fetcher_state, core_state;
    logic [1:0] lsu_state [T];
    logic [PB-1:0] next_pc [T];
    logic [PB-1:0] current_pc;
    logic [T-1:0] active_mask;
    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    simt_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .thread_count(thread_count),
        .fetcher_state(fetcher_state),
        .decoded_mem_read_enable(rd),
        .decoded_mem_write_enable(wr),
        .decoded_ret(ret),
        .lsu_state(lsu_state),
        .next_pc(next_pc),
        .core_state(core_state),
        .current_pc(current_pc),
        .active_mask(active_mask),
        .diverged(diverged),
        .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [7:0] pc, input logic [3:0] m,
                                input logic dv, input logic dn);
        mk = {st, pc, m, dv, dn};
    endfunction

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 50 && core_state !== s; i++) tick();
        if (core_state !== s) check({tag, "_timeout"}, {29'd0, core_state}, {29'd0, s});
    endtask

    task automatic set_np(input logic [31:0] nps);
        for (int i = 0; i < T; i++) next_pc[i] = nps[8*i +: 8];
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, {29'd0, core_state}, {29'd0, CORE_IDLE});
        check({tag, "_pc"}, {24'd0, current_pc}, 32'd0);
        check({tag, "_mask"}, {28'd0, active_mask}, 32'd0);
        check({tag, "_div"}, {31'd0, diverged}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_state"}, {29'd0, core_state}, {29'd0, e.st});
        check({tag, "_mask"}, {28'd0, active_mask}, {28'd0, e.mask});
        check({tag, "_div"}, {31'd0, diverged}, {31'd0, e.dv});
        check({tag, "_done"}, {31'd0, done}, {31'd0, e.dn});
        if (!e.dn) check({tag, "_pc"}, {24'd0, current_pc}, {24'd0, e.pc});
    endtask

    task automatic to_decode(input string tag);
        wait_state(CORE_FETCH, tag);
        fetcher_state = 3'b000;
        tick(2);
        check({tag, "_fetch_hold"}, {29'd0, core_state}, {29'd0, CORE_FETCH});
        fetcher_state = FETCHER_DONE;
        tick();
        check({tag, "_decode"}, {29'd0, core_state}, {29'd0, CORE_DECODE});
        fetcher_state = 3'b000;
    endtask

    task automatic run_instr(input string tag, input logic [31:0] nps, input logic r, input exp_t e);
        to_decode(tag);
        ret = r;
        set_np(nps);
        sb.push_back(e);
        tick(); check({tag, "_req"}, {29'd0, core_state}, {29'd0, CORE_REQUEST});
        tick(); check({tag, "_wait"}, {29'd0, core_state}, {29'd0, CORE_WAIT});
        tick(); check({tag, "_exec"}, {29'd0, core_state}, {29'd0, CORE_EXECUTE});
        tick(); check({tag, "_upd"}, {29'd0, core_state}, {29'd0, CORE_UPDATE});
        tick();
        compare_out(tag);
        ret = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; thread_count = 3'd4; fetcher_state = 3'b000;
        rd = 1'b0; wr = 1'b0; ret = 1'b0;
        lsu_state = '{default: LSU_IDLE};
        set_np(32'd0);
        tick(3);
        check_zero("rst");
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(mk(CORE_FETCH, 8'd0, 4'b1111, 1'b0, 1'b0));
        compare_out("start4");
        run_instr("u0", {4{8'd1}}, 1'b0, mk(CORE_FETCH, 8'd1, 4'b1111, 1'b0, 1'b0));
        run_instr("u1", {4{8'd2}}, 1'b0, mk(CORE_FETCH, 8'd2, 4'b1111, 1'b0, 1'b0));
        run_instr("jmp", {4{8'd5}}, 1'b0, mk(CORE_FETCH, 8'd5, 4'b1111, 1'b0, 1'b0));
        run_instr("div", {8'd6, 8'd8, 8'd6, 8'd8}, 1'b0, mk(CORE_FETCH, 8'd6, 4'b1010, 1'b1, 1'b0));
        run_instr("d1", {8'd7, 8'd0, 8'd7, 8'd0}, 1'b0, mk(CORE_FETCH, 8'd7, 4'b1010, 1'b1, 1'b0));
        run_instr("reconv", {8'd8, 8'd33, 8'd8, 8'd33}, 1'b0, mk(CORE_FETCH, 8'd8, 4'b1111, 1'b0, 1'b0));
        run_instr("br", {8'd9, 8'd12, 8'd9, 8'd12}, 1'b0, mk(CORE_FETCH, 8'd9, 4'b1010, 1'b1, 1'b0));
        // LDR with t1/t3 active: t0 waits forever but is inactive, t1 finishes after 5 cycles
        to_decode("lsu");
        rd = 1'b1;
        lsu_state = '{LSU_WAITING, LSU_WAITING, LSU_IDLE, LSU_DONE};
        set_np({8'd10, 8'd99, 8'd10, 8'd99});
        sb.push_back(mk(CORE_FETCH, 8'd10, 4'b1010, 1'b1, 1'b0));
        tick(2);
        check("lsu_wait_enter", {29'd0, core_state}, {29'd0, CORE_WAIT});
        repeat (4) begin
            tick();
            check("lsu_hold", {29'd0, core_state}, {29'd0, CORE_WAIT});
        end
        lsu_state[1] = LSU_DONE;
        tick();
        check("lsu_exit", {29'd0, core_state}, {29'd0, CORE_EXECUTE});
        tick(2);
        compare_out("lsu");
        rd = 1'b0;
        lsu_state = '{default: LSU_IDLE};
        run_instr("ret1", 32'd0, 1'b1, mk(CORE_FETCH, 8'd12, 4'b0101, 1'b0, 1'b0));
        run_instr("ret2", 32'd0, 1'b1, mk(CORE_DONE, 8'd0, 4'b0000, 1'b0, 1'b1));
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            tick();
            check("done_hold", {29'd0, core_state, done}, {28'd0, CORE_DONE, 1'b1});
        end
        start = 1'b0;
        reset = 1'b1;
        thread_count = 3'd3;
        tick(2);
        check_zero("rst2");
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(mk(CORE_FETCH, 8'd0, 4'b0111, 1'b0, 1'b0));
        compare_out("start3");
        run_instr("p0", {8'hFF, 8'd1, 8'd1, 8'd1}, 1'b0, mk(CORE_FETCH, 8'd1, 4'b0111, 1'b0, 1'b0));
        run_instr("p1", {8'hFF, 8'd2, 8'd2, 8'd2}, 1'b0, mk(CORE_FETCH, 8'd2, 4'b0111, 1'b0, 1'b0));
        to_decode("rstw");
        rd = 1'b1;
        lsu_state[0] = LSU_WAITING;
        tick(3);
        check("rstw_held", {29'd0, core_state}, {29'd0, CORE_WAIT});
        reset = 1'b1;
        tick();
        check_zero("rstw");
        reset = 1'b0;
        rd = 1'b0;
        lsu_state = '{default: LSU_IDLE};
        thread_count = 3'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        sb.push_back(mk(CORE_DONE, 8'd0, 4'b0000, 1'b0, 1'b1));
        compare_out("tc0");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
